// File: rtl/sim_ctrl.sv
// Simulation run controller: tracks an ISA test run, decides how it ended
// (pass / fail / timeout / software end) and raises one-shot interrupt requests.
module sim_ctrl #(
  parameter int CNT_W      = 64,
  parameter int TIMEOUT    = 300000,
  parameter int SETTLE     = 3,
  parameter int IRQ_N      = 1,
  parameter int IRQ_AT     = 1500,
  parameter int IRQ_STRIDE = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             isa_done,
  input  logic             isa_pass,
  input  logic [31:0]      testnum,
  input  logic             mends,
  input  logic [IRQ_N-1:0] irq_ready,
  output logic [IRQ_N-1:0] irq_valid,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state,
  output logic             end_valid,
  output logic [1:0]       end_code,
  output logic [31:0]      fail_num
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [1:0] CODE_PASS    = 2'd0;
  localparam logic [1:0] CODE_FAIL    = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;
  localparam logic [1:0] CODE_MENDS   = 2'd3;

  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [7:0]       SETTLE_M1  = 8'(SETTLE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_settle;
  logic             r_end_valid;
  logic [1:0]       r_end_code;
  logic [31:0]      r_fail_num;
  logic [IRQ_N-1:0] r_irq_valid;
  logic [IRQ_N-1:0] r_irq_done;

  logic             w_timeout;
  logic             w_counting;
  logic [1:0]       w_end_code;
  logic [31:0]      w_fail_num;
  logic [IRQ_N-1:0] w_irq_hit;

  assign w_timeout  = (r_cnt == TIMEOUT_M1);
  assign w_counting = (r_state == S_RUN) || (r_state == S_SETTLE);

  // Exit priority in RUN: isa_done, then mends, then timeout.
  always_comb begin
    w_next     = r_state;
    w_end_code = r_end_code;
    w_fail_num = r_fail_num;
    case (r_state)
      S_IDLE: begin
        if (run_en) w_next = S_RUN;
      end
      S_RUN: begin
        if (isa_done) begin
          w_next = S_SETTLE;
        end else if (mends) begin
          w_next     = S_END;
          w_end_code = CODE_MENDS;
        end else if (w_timeout) begin
          w_next     = S_END;
          w_end_code = CODE_TIMEOUT;
        end
      end
      S_SETTLE: begin
        if (r_settle == 8'd0) begin
          w_next = S_END;
          if (isa_pass) begin
            w_end_code = CODE_PASS;
          end else begin
            w_end_code = CODE_FAIL;
            w_fail_num = testnum;
          end
        end
      end
      S_END: begin
        w_next = S_END;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_settle    <= 8'd0;
      r_end_valid <= 1'b0;
      r_end_code  <= 2'd0;
      r_fail_num  <= 32'd0;
    end else begin
      r_state     <= w_next;
      r_end_code  <= w_end_code;
      r_fail_num  <= w_fail_num;
      r_end_valid <= (w_next == S_END) && (r_state != S_END);
      if (w_counting && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_ONE;
      if ((r_state == S_RUN) && isa_done) begin
        r_settle <= SETTLE_M1;
      end else if ((r_state == S_SETTLE) && (r_settle != 8'd0)) begin
        r_settle <= r_settle - 8'd1;
      end
    end
  end

  // A channel fires at the edge where the counter equals its request cycle,
  // so the request becomes visible one cycle later. Handshake: a request is
  // transferred on the edge where irq_valid[i] and irq_ready[i] are both high;
  // ready with valid low has no effect, and valid never drops without ready.
  for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_irq
    localparam logic [CNT_W-1:0] REQ_AT = CNT_W'(IRQ_AT + gi * IRQ_STRIDE);

    assign w_irq_hit[gi] = (r_state == S_RUN) && (r_cnt == REQ_AT) && !r_irq_done[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_irq_valid[gi] <= 1'b0;
        r_irq_done[gi]  <= 1'b0;
      end else if (w_irq_hit[gi]) begin
        r_irq_valid[gi] <= 1'b1;
        r_irq_done[gi]  <= 1'b1;
      end else if (r_irq_valid[gi] && irq_ready[gi]) begin
        r_irq_valid[gi] <= 1'b0;
      end
    end
  end

  assign irq_valid = r_irq_valid;
  assign cycle_cnt = r_cnt;
  assign state     = r_state;
  assign end_valid = r_end_valid;
  assign end_code  = r_end_code;
  assign fail_num  = r_fail_num;

endmodule

// File: tb/tb_sim_ctrl.sv
// Directed bench for sim_ctrl: a table of end-of-test scenarios plus
// hand-written interrupt and mid-run reset sequences.
module tb_sim_ctrl;

  localparam int CNT_W = 64;
  localparam int IRQ_N = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run_en = 1'b0;
  logic             isa_done = 1'b0;
  logic             isa_pass = 1'b0;
  logic [31:0]      testnum = 32'd0;
  logic             mends = 1'b0;
  logic [IRQ_N-1:0] irq_ready = '0;
  logic [IRQ_N-1:0] irq_valid;
  logic [CNT_W-1:0] cycle_cnt;
  logic [1:0]       state;
  logic             end_valid;
  logic [1:0]       end_code;
  logic [31:0]      fail_num;

  int n_checks = 0;
  int n_errors = 0;

  sim_ctrl #(
    .CNT_W(CNT_W), .TIMEOUT(1000), .SETTLE(3),
    .IRQ_N(IRQ_N), .IRQ_AT(100), .IRQ_STRIDE(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .isa_done(isa_done),
    .isa_pass(isa_pass), .testnum(testnum), .mends(mends),
    .irq_ready(irq_ready), .irq_valid(irq_valid), .cycle_cnt(cycle_cnt),
    .state(state), .end_valid(end_valid), .end_code(end_code),
    .fail_num(fail_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done_at;   // -1: never
    int          mends_at;  // -1: never
    logic        pass;
    logic [31:0] tnum;
    logic [1:0]  code;
    logic [31:0] fnum;
    longint      end_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run_en = 1'b0; isa_done = 1'b0; isa_pass = 1'b0;
    mends = 1'b0; testnum = 32'd0; irq_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    @(negedge clk);
    run_en = 1'b1;
    @(posedge clk); #1;
    run_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_cnt"}, cycle_cnt, 64'd0);
    check({tag, "_end_valid"}, 64'(end_valid), 64'd0);
    check({tag, "_end_code"}, 64'(end_code), 64'd0);
    check({tag, "_fail_num"}, 64'(fail_num), 64'd0);
    check({tag, "_irq"}, 64'(irq_valid), 64'd0);
  endtask

  initial begin
    int c;
    bit saw;
    logic [1:0] exp_irq;

    //          done  mends pass tnum code fnum end_cnt
    vecs[0] = '{500,  -1,   1'b1, 32'd9,  2'd0, 32'd0,  504};
    vecs[1] = '{300,  -1,   1'b0, 32'd17, 2'd1, 32'd17, 304};
    vecs[2] = '{-1,   -1,   1'b1, 32'd4,  2'd2, 32'd0,  1000};
    vecs[3] = '{200,  200,  1'b1, 32'd6,  2'd0, 32'd0,  204};
    vecs[4] = '{-1,   250,  1'b0, 32'd8,  2'd3, 32'd0,  251};
    vecs[5] = '{999,  -1,   1'b0, 32'd5,  2'd1, 32'd5,  1003};
    vecs[6] = '{-1,   999,  1'b1, 32'd3,  2'd3, 32'd0,  1000};
    vecs[7] = '{0,    -1,   1'b1, 32'd2,  2'd0, 32'd0,  4};

    #3;
    check_zero("por");

    for (int v = 0; v < 8; v++) begin
      do_reset();
      start_run();
      check($sformatf("v%0d_run_state", v), 64'(state), 64'd1);
      check($sformatf("v%0d_run_cnt", v), cycle_cnt, 64'd0);
      isa_pass = vecs[v].pass;
      testnum = vecs[v].tnum;
      irq_ready = '1;
      c = 0;
      saw = 1'b0;
      for (int g = 0; g < 1200 && !saw; g++) begin
        isa_done = (c == vecs[v].done_at);
        mends = (c == vecs[v].mends_at);
        @(posedge clk); #1;
        c++;
        if (vecs[v].done_at >= 0 && c == vecs[v].done_at + 1)
          check($sformatf("v%0d_settle_entry", v), 64'(state), 64'd2);
        if (end_valid) saw = 1'b1;
      end
      isa_done = 1'b0;
      mends = 1'b0;
      check($sformatf("v%0d_end_seen", v), 64'(saw), 64'd1);
      check($sformatf("v%0d_end_cnt", v), cycle_cnt, 64'(vecs[v].end_cnt));
      check($sformatf("v%0d_end_code", v), 64'(end_code), 64'(vecs[v].code));
      check($sformatf("v%0d_fail_num", v), 64'(fail_num), 64'(vecs[v].fnum));
      check($sformatf("v%0d_end_state", v), 64'(state), 64'd3);
      // END must be sticky and deaf to every input
      mends = 1'b1; run_en = 1'b1; isa_done = 1'b1; isa_pass = ~vecs[v].pass;
      testnum = 32'hdead;
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_width", v), 64'(end_valid), 64'd0);
      check($sformatf("v%0d_cnt_frozen", v), cycle_cnt, 64'(vecs[v].end_cnt));
      check($sformatf("v%0d_state_sticky", v), 64'(state), 64'd3);
      check($sformatf("v%0d_code_hold", v), 64'(end_code), 64'(vecs[v].code));
      check($sformatf("v%0d_fnum_hold", v), 64'(fail_num), 64'(vecs[v].fnum));
    end

    // Interrupt sequence: ch0 acked at 120, stray acks ignored, ch1 held into END.
    do_reset();
    start_run();
    c = 0;
    for (int g = 0; g < 260; g++) begin
      irq_ready[0] = (c == 120) || (c == 200);
      irq_ready[1] = (c == 130) || (c == 255);
      mends = (c == 250);
      @(posedge clk); #1;
      c++;
      exp_irq[0] = (c >= 101) && (c <= 120);
      exp_irq[1] = (c >= 151) && (c <= 255);
      check($sformatf("irq_c%0d", c), 64'(irq_valid), 64'(exp_irq));
    end
    irq_ready = '0;
    mends = 1'b0;
    check("irq_end_state", 64'(state), 64'd3);
    check("irq_end_code", 64'(end_code), 64'd3);

    // Reset during SETTLE with a pending interrupt, then a fresh run.
    do_reset();
    start_run();
    isa_pass = 1'b1;
    c = 0;
    for (int g = 0; g < 111; g++) begin
      isa_done = (c == 110);
      @(posedge clk); #1;
      c++;
    end
    isa_done = 1'b0;
    check("rst_pre_state", 64'(state), 64'd2);
    check("rst_pre_irq", 64'(irq_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    check_zero("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_idle");
    start_run();
    check("rerun_state", 64'(state), 64'd1);
    check("rerun_cnt", cycle_cnt, 64'd0);
    c = 0;
    for (int g = 0; g < 101; g++) begin
      @(posedge clk); #1;
      c++;
    end
    check("rerun_cnt_101", cycle_cnt, 64'd101);
    check("rerun_irq_again", 64'(irq_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sim_ctrl.md
SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 Parameter CNT_W, default 64, is the cycle counter width.
REQ-002 Parameter TIMEOUT, default 300000, is the cycle count at which a test is declared timed out.
REQ-003 Parameter SETTLE, default 3, is the number of cycles between isa_done and sampling isa_pass (valid range 1..255).
REQ-004 Parameter IRQ_N, default 1, is the number of external-interrupt request channels (valid range 1..8).
REQ-005 Parameter IRQ_AT, default 1500, is the cycle count at which channel 0 requests an interrupt.
REQ-006 Parameter IRQ_STRIDE, default 100, is the cycle offset between consecutive channels; channel i requests at IRQ_AT + i*IRQ_STRIDE.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 run_en  input  1  level; starts the test run.
REQ-010 isa_done  input  1  level; ISA test finished (x26 == 1).
REQ-011 isa_pass  input  1  level; ISA test result (x27 == 1).
REQ-012 testnum  input  32  current test number (x3).
REQ-013 mends  input  1  level; software end-of-simulation flag from the CSR.
REQ-014 irq_ready  input  IRQ_N  per-channel interrupt acknowledge.
REQ-015 irq_valid  output  IRQ_N  per-channel interrupt request.
REQ-016 cycle_cnt  output  CNT_W  cycles elapsed since the run started.
REQ-017 state  output  2  current FSM state.
REQ-018 end_valid  output  1  one-cycle pulse when the test ends.
REQ-019 end_code  output  2  end reason: 0 pass, 1 fail, 2 timeout, 3 mends.
REQ-020 fail_num  output  32  testnum latched at a fail.

Function
REQ-021 FSM states SHALL be IDLE=0, RUN=1, SETTLE=2 and END=3.
REQ-022 IDLE SHALL go to RUN on the first clk edge with run_en=1; after that, run_en SHALL be ignored.
REQ-023 cycle_cnt SHALL increment by 1 per cycle in RUN and SETTLE, hold in IDLE and END, and saturate at all-ones.
REQ-024 In RUN, exit conditions SHALL have priority isa_done > mends > timeout (cycle_cnt == TIMEOUT-1) when several are true in the same cycle.
REQ-025 On isa_done in RUN, the FSM SHALL go to SETTLE and load an 8-bit settle counter with SETTLE-1.
REQ-026 SETTLE SHALL decrement the settle counter each cycle; in the cycle it reads 0, the block SHALL sample isa_pass and go to END.
  - isa_pass=1: end_code=0.
  - isa_pass=0: end_code=1 and fail_num=testnum (sampled in that same cycle).
REQ-027 In SETTLE, mends and timeout SHALL be ignored.
REQ-028 On mends in RUN (with isa_done=0), the FSM SHALL go to END with end_code=3.
REQ-029 On timeout in RUN (with isa_done=0 and mends=0), the FSM SHALL go to END with end_code=2.
REQ-030 end_valid SHALL be high for exactly the first cycle in END.
REQ-031 END SHALL be sticky until reset; end_code and fail_num SHALL hold there.
REQ-032 Each channel i SHALL set irq_valid[i] at the edge where cycle_cnt == IRQ_AT + i*IRQ_STRIDE while in RUN.
REQ-033 irq_valid[i] SHALL stay high until irq_ready[i] is sampled high, then clear on that edge.
REQ-034 Each channel SHALL request at most once per reset (one-shot done flag).
REQ-035 irq_ready[i] arriving while irq_valid[i]=0 SHALL be ignored.
REQ-036 A pending irq_valid SHALL stay asserted through SETTLE and END until it is acknowledged.
REQ-037 Channels whose request cycle is never reached SHALL never assert.
REQ-038 TIMEOUT and the IRQ cycle values SHALL be compared at CNT_W width; parameters that do not fit in CNT_W are illegal.

Reset
REQ-039 While rst_n=0, these outputs SHALL be 0 immediately (asynchronously), independent of clk: state (IDLE), cycle_cnt, end_valid, end_code, fail_num, irq_valid.
REQ-040 While rst_n=0, the settle counter and IRQ done flags SHALL also be 0.
REQ-041 Reset asserted mid-run (any state) SHALL abort the run completely; after release, the block SHALL wait in IDLE for run_en.

Verification
REQ-042 Pass case (SETTLE=3): run_en=1, isa_done=1 at cycle_cnt=500, isa_pass=1 -> 3 cycles in SETTLE, then state=3, end_valid one pulse, end_code=0, fail_num=0.
REQ-043 Fail case: isa_done=1 with isa_pass=0 and testnum=17 -> end_code=1, fail_num=17.
REQ-044 Timeout case (TIMEOUT=1000), no done and no mends -> end at cycle_cnt=999, end_code=2; cycle_cnt then frozen at 1000.
REQ-045 Simultaneous case: isa_done=1 and mends=1 in the same RUN cycle -> SETTLE path taken and mends ignored; separately, mends alone -> end_code=3.
REQ-046 Interrupt case (IRQ_N=2, IRQ_AT=100, IRQ_STRIDE=50): irq_valid[0] rises at cycle 100 and irq_valid[1] at cycle 150; irq_ready[0] pulsed at 120 -> irq_valid[0] drops at 120 and never re-asserts; irq_valid[1] held until its ready arrives.
REQ-047 Reset case: rst_n dropped in SETTLE and released -> all outputs 0, state=IDLE; a new run_en restarts cycle_cnt from 0.
